// File: rtl/linebuff_pkg.sv
// Shared types and constants for the FIR line-buffer storage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package linebuff_pkg;

    // Storage sequencer: CLEAR sweeps zeros through every word, READY serves accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } lb_state_t;

    // Default number of words: one per pixel of the widest supported line.
    localparam int LINE_MAX_DEFAULT = 1920;

    // One word holds the previous (taps-1) lines of a single pixel column.
    function automatic int word_width(input int data_width, input int tap_nums);
        return (tap_nums - 1) * data_width;
    endfunction

endpackage

// File: rtl/linebuff_ram.sv
// Simple dual-port word array: one write port, one read-first registered read port.
// Latency: read data appears on rd_word one cycle after rd_en; writes land at the edge.
// Backpressure: none; both ports accept a request every cycle.
//
// Ports: clk; wr_en/wr_idx/wr_word write port; rd_en/rd_idx read request;
//        rd_word registered read data (holds when rd_en=0, not reset).
module linebuff_ram
    import linebuff_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int DEPTH  = LINE_MAX_DEFAULT,
    parameter int IDX_W  = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Both ports in one block with non-blocking updates: a same-address
    // read and write in one cycle returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
        if (rd_en) begin
            rd_word <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/linebuff_mem.sv
// Line-buffer storage for the 2D FIR: one packed column word per pixel, with a clear sweeper.
// Latency: reads return one cycle after the request; writes are visible to the next cycle's read.
// Backpressure: none per access; ready_o=0 for LINE_MAX cycles while a clear sweep runs.
//
// Ports: clk, rst_n (async, active low); init_i starts a clear sweep when ready_o=1;
//        rd_en_i/rd_addr_i -> rd_valid_o/rd_data_o; wr_en_i/wr_addr_i/wr_data_i;
//        err_o sticky out-of-range flag, err_clr_i clears it.
// Build option: LINEBUFF_MEM_BYPASS_EN selects write-first forwarding for a same-cycle
//        same-address read and write; without it the old word is returned (read-first).
module linebuff_mem
    import linebuff_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int TAP_NUMS   = 3,
    parameter int LINE_MAX   = LINE_MAX_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                init_i,
    output logic                                ready_o,
    input  logic                                rd_en_i,
    input  logic [ADDR_WIDTH-1:0]               rd_addr_i,
    output logic [(TAP_NUMS-1)*DATA_WIDTH-1:0]  rd_data_o,
    output logic                                rd_valid_o,
    input  logic                                wr_en_i,
    input  logic [ADDR_WIDTH-1:0]               wr_addr_i,
    input  logic [(TAP_NUMS-1)*DATA_WIDTH-1:0]  wr_data_i,
    output logic                                err_o,
    input  logic                                err_clr_i
);

    localparam int                    WORD_W   = word_width(DATA_WIDTH, TAP_NUMS);
    localparam int                    IDX_W    = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam logic [ADDR_WIDTH-1:0] LIMIT    = ADDR_WIDTH'(LINE_MAX);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(LINE_MAX - 1);

    lb_state_t         state_q;
    logic [IDX_W-1:0]  sweep_q;

    logic              is_ready;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_acc;
    logic              wr_acc;
    logic              ram_rd_en;
    logic              err_set;
    logic              byp_hit;

    logic              ram_wr_en;
    logic [IDX_W-1:0]  ram_wr_idx;
    logic [WORD_W-1:0] ram_wr_word;
    logic [IDX_W-1:0]  ram_rd_idx;
    logic [WORD_W-1:0] ram_rd_word;

    logic              rd_vld_q;
    logic              rd_zero_q;
    logic              byp_q;
    logic [WORD_W-1:0] byp_data_q;
    logic [WORD_W-1:0] hold_q;
    logic [WORD_W-1:0] fresh_word;
    logic              err_q;

    assign is_ready = (state_q == READY);

    // Full-width compare, so wrapped counters (e.g. 0xFFFF_FFFE) are caught
    // before the address is truncated to an array index.
    assign rd_ok = (rd_addr_i < LIMIT);
    assign wr_ok = (wr_addr_i < LIMIT);

    assign rd_acc    = is_ready && rd_en_i;
    assign wr_acc    = is_ready && wr_en_i && wr_ok;
    assign ram_rd_en = rd_acc && rd_ok;
    assign err_set   = is_ready && ((rd_en_i && !rd_ok) || (wr_en_i && !wr_ok));

    assign ram_rd_idx = rd_addr_i[IDX_W-1:0];

`ifdef LINEBUFF_MEM_BYPASS_EN
    assign byp_hit = ram_rd_en && wr_acc && (rd_addr_i == wr_addr_i);
`else
    assign byp_hit = 1'b0;
`endif

    // The sweeper owns the write port while clearing; external writes are ignored then.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_idx  = wr_addr_i[IDX_W-1:0];
        ram_wr_word = wr_data_i;
        if (!is_ready) begin
            ram_wr_en   = 1'b1;
            ram_wr_idx  = sweep_q;
            ram_wr_word = '0;
        end else if (wr_acc) begin
            ram_wr_en = 1'b1;
        end
    end

    linebuff_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (LINE_MAX),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_idx  (ram_wr_idx),
        .wr_word (ram_wr_word),
        .rd_en   (ram_rd_en),
        .rd_idx  (ram_rd_idx),
        .rd_word (ram_rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (sweep_q == LAST_IDX) begin
                        state_q <= READY;
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + IDX_W'(1);
                    end
                end
                READY: begin
                    if (init_i) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    sweep_q <= '0;
                end
            endcase
        end
    end

    // Read-side tags for the word the RAM presents next cycle: out-of-range
    // reads answer zero, forwarded reads answer the captured write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_zero_q  <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_acc;
            rd_zero_q <= rd_acc && !rd_ok;
            byp_q     <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= wr_data_i;
            end
        end
    end

    always_comb begin
        fresh_word = ram_rd_word;
        if (rd_zero_q) begin
            fresh_word = '0;
        end else if (byp_q) begin
            fresh_word = byp_data_q;
        end
    end

    // The RAM output register is not reset, so a resettable shadow supplies
    // rd_data_o between valid cycles and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (rd_vld_q) begin
            hold_q <= fresh_word;
        end
    end

    // Sticky error; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign ready_o    = is_ready;
    assign rd_valid_o = rd_vld_q;
    assign rd_data_o  = rd_vld_q ? fresh_word : hold_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_linebuff_mem.sv
// Randomised scoreboard bench for linebuff_mem with a 16-word array.
// Latency: expected read words are queued at the request edge and popped on the following negedge.
// Backpressure: the reference model tracks the clear sweep as a count of busy cycles.
module tb_linebuff_mem;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TN = 3;
    localparam int LM = 16;
    localparam int WW = (TN - 1) * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_i;
    logic          ready_o;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [WW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [WW-1:0] wr_data_i;
    logic          err_o;
    logic          err_clr_i;

    always #5 clk = ~clk;

    linebuff_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TAP_NUMS   (TN),
        .LINE_MAX   (LM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_i     (init_i),
        .ready_o    (ready_o),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i)
    );

    // Reference model: plain array of words, busy-cycle count for the sweep,
    // sticky error bit, last delivered word, and a queue of pending reads.
    logic [WW-1:0] mem_m [LM];
    int            busy;
    logic          err_m;
    logic [WW-1:0] last_m;
    logic [WW-1:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Applies the rules of one clock edge to the model, using the inputs held across that edge.
    task automatic model_edge();
        logic rd_ok;
        logic wr_ok;
        logic [WW-1:0] e;
        rd_ok = (rd_addr_i < 32'(LM));
        wr_ok = (wr_addr_i < 32'(LM));
        if (busy > 0) begin
            busy--;
            if (err_clr_i) err_m = 1'b0;
        end else begin
            if (rd_en_i) begin
                if (!rd_ok) begin
                    e = '0;
                end else if (wr_en_i && wr_ok && rd_addr_i == wr_addr_i) begin
`ifdef LINEBUFF_MEM_BYPASS_EN
                    e = wr_data_i;
`else
                    e = mem_m[rd_addr_i[3:0]];
`endif
                end else begin
                    e = mem_m[rd_addr_i[3:0]];
                end
                exp_q.push_back(e);
            end
            if (wr_en_i && wr_ok) mem_m[wr_addr_i[3:0]] = wr_data_i;
            if ((rd_en_i && !rd_ok) || (wr_en_i && !wr_ok)) err_m = 1'b1;
            else if (err_clr_i) err_m = 1'b0;
            if (init_i) begin
                busy = LM;
                for (int i = 0; i < LM; i++) mem_m[i] = '0;
            end
        end
    endtask

    task automatic step(input logic rd, input logic [AW-1:0] ra, input logic wr,
                        input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                        input logic ini, input logic clr);
        rd_en_i   = rd;
        rd_addr_i = ra;
        wr_en_i   = wr;
        wr_addr_i = wa;
        wr_data_i = wd;
        init_i    = ini;
        err_clr_i = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        rst_n     = 1'b0;
        rd_en_i   = 1'b0;
        wr_en_i   = 1'b0;
        init_i    = 1'b0;
        err_clr_i = 1'b0;
        rd_addr_i = '0;
        wr_addr_i = '0;
        wr_data_i = '0;
        exp_q.delete();
        busy   = LM;
        err_m  = 1'b0;
        last_m = '0;
        for (int i = 0; i < LM; i++) mem_m[i] = '0;
        repeat (hold) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) return 32'hFFFF_FFFE;
        if (k == 1) return 32'(LM + $urandom_range(0, 100));
        if (k == 2) return 32'($urandom);
        return 32'($urandom_range(0, LM - 1));
    endfunction

    // Monitor: every negedge compares status outputs and the read channel with the model.
    always @(negedge clk) begin
        logic [WW-1:0] e;
        logic exp_v;
        check("ready", 32'(ready_o), 32'(busy == 0));
        check("err", 32'(err_o), 32'(err_m));
        exp_v = (exp_q.size() > 0);
        check("rd_valid", 32'(rd_valid_o), 32'(exp_v));
        if (exp_v) begin
            e = exp_q.pop_front();
            check("rd_data", 32'(rd_data_o), 32'(e));
            last_m = e;
        end else begin
            check("rd_hold", 32'(rd_data_o), 32'(last_m));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        repeat (LM) idle();

        // Every word reads back zero after the power-up sweep.
        for (int a = 0; a < LM; a++) step(1'b1, 32'(a), 1'b0, '0, '0, 1'b0, 1'b0);
        idle();

        // Write then read on the next cycle.
        step(1'b0, '0, 1'b1, 32'd5, 16'hA5B6, 1'b0, 1'b0);
        step(1'b1, 32'd5, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();

        // Same-cycle read and write to one address.
        step(1'b0, '0, 1'b1, 32'd7, 16'h0F0F, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b1, 32'd7, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();

        // Wrapped write address is dropped and flagged; array untouched.
        step(1'b0, '0, 1'b1, 32'hFFFF_FFFE, 16'hBEEF, 1'b0, 1'b0);
        for (int a = 0; a < LM; a++) step(1'b1, 32'(a), 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 32'd16, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle();
        step(1'b1, 32'd16, 1'b0, '0, '0, 1'b0, 1'b1);
        idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

        // Fill, clear on request, accesses ignored during the sweep, zeros afterwards.
        for (int a = 0; a < LM; a++) step(1'b0, '0, 1'b1, 32'(a), 16'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int c = 0; c < LM; c++)
            step(1'b1, rand_addr(), 1'b1, rand_addr(), 16'($urandom), 1'b0, 1'b0);
        for (int a = 0; a < LM; a++) step(1'b1, 32'(a), 1'b0, '0, '0, 1'b0, 1'b0);
        idle();

        // Reset in the middle of a sweep restarts it from the beginning.
        step(1'b1, 32'd3, 1'b1, 32'hFFFF_FFFF, 16'h5555, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        repeat (9) idle();
        do_reset(2);
        repeat (LM) idle();
        for (int a = 0; a < 4; a++) step(1'b1, 32'(a), 1'b0, '0, '0, 1'b0, 1'b0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            logic rd;
            logic wr;
            logic ini;
            logic clr;
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            ini = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 3) == 0);
            ra  = rand_addr();
            wa  = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
            step(rd, ra, wr, wa, 16'($urandom), ini, clr);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
